bk_mp_add_seq: RTL

BK_MP_ADD_SEQ -- requirements
Module: bk_mp_add_seq

---
 rtl/bk_mp_add_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bk_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : bk_mp_add_seq (with helper bk_add16)
// Description : Multi-precision add/subtract sequencer. One 16-bit
//               Brent-Kung adder is reused word by word, LSW first, with the
//               carry held in a register between words.
// Revision    : 1.0 - initial release
// ============================================================================

// 16-bit Brent-Kung parallel-prefix adder with carry-in.
module bk_add16 (
  output logic [15:0] sum,
  output logic        cout,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);
  // Up-sweep generate/propagate per level, then down-sweep carries.
  logic [15:0] g [0:4];
  logic [15:0] p [0:4];
  logic [15:0] c [0:3];

  // Bit 0 generate absorbs the carry-in, so the prefix G[i] is the carry out of bit i.
  generate
    for (genvar i = 0; i < 16; i++) begin : g_pre
      if (i == 0) begin : g_bit0
        assign g[0][i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cin);
      end else begin : g_bitn
        assign g[0][i] = a[i] & b[i];
      end
      assign p[0][i] = a[i] ^ b[i];
    end

    // Up-sweep: combine span-aligned nodes, doubling the span each level.
    for (genvar l = 0; l < 4; l++) begin : g_up_lvl
      for (genvar i = 0; i < 16; i++) begin : g_up_bit
        if (((i + 1) % (2 << l)) == 0) begin : g_comb
          assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin : g_pass
          assign g[l+1][i] = g[l][i];
          assign p[l+1][i] = p[l][i];
        end
      end
    end

    assign c[0] = g[4];

    // Down-sweep: fill in the remaining prefixes from the completed ones.
    for (genvar d = 0; d < 3; d++) begin : g_dn_lvl
      localparam int L = 2 - d;
      for (genvar i = 0; i < 16; i++) begin : g_dn_bit
        if ((((i + 1) % (2 << L)) == (1 << L)) && (i >= 3 * (1 << L) - 1)) begin : g_comb
          assign c[d+1][i] = c[d][i] | (p[4][i] & c[d][i-(1<<L)]);
        end else begin : g_pass
          assign c[d+1][i] = c[d][i];
        end
      end
    end
  endgenerate

  assign sum  = p[0] ^ {c[3][14:0], cin};
  assign cout = c[3][15];
endmodule

module bk_mp_add_seq #(
  parameter int NW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*NW-1:0] in_a,
  input  logic [16*NW-1:0] in_b,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*NW-1:0] out_sum,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            busy
);
  localparam int W  = 16 * NW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;   // already inverted for subtract
  logic [IW+3:0] base;
  logic [15:0]   add_sum;
  logic          add_cout;

  assign base = {idx, 4'b0000};

  bk_add16 u_add (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (a_reg[base +: 16]),
    .b    (b_reg[base +: 16]),
    .cin  (carry)
  );

  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN);

  // Sequencer: latch operands, walk the words LSW first, then hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          out_sum[base +: 16] <= add_sum;
          carry               <= add_cout;
          if (idx == LAST) begin
            out_cout <= add_cout;
            // Same-sign operands whose result sign differs signal overflow.
            out_ovf  <= (a_reg[W-1] == b_reg[W-1]) & (add_sum[15] != a_reg[W-1]);
            idx      <= '0;
            state    <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
